// File: rtl/adder_dp_pkg.sv
// Shared widths and mux-select encodings for the sum-of-1..N adder datapath.
package adder_dp_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;
    localparam int unsigned SUM_W_DEFAULT = 16;

    localparam logic MUX_ZERO = 1'b0;
    localparam logic MUX_INC  = 1'b1;

endpackage

// File: rtl/dp_register.sv
// Load-enabled datapath register with synchronous active-low reset.
module dp_register #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] reg_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_q <= '0;
        end else if (en_i) begin
            reg_q <= d_i;
        end
    end

    assign q_o = reg_q;

endmodule

// File: rtl/adder_datapath.sv
// Datapath for the sum-of-1..N processor: loop counter, accumulator, latched limit,
// compare flag back to the controller and a registered result with sticky overflow.
module adder_datapath
    import adder_dp_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT,
    parameter int unsigned SUM_W = SUM_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MuxSel,
    input  logic             En,
    input  logic             MuxSel_2,
    input  logic             En_2,
    input  logic             OutBuf,
    input  logic [CNT_W-1:0] limit,
    output logic             lt,
    output logic [SUM_W-1:0] out_data,
    output logic             out_valid,
    output logic             overflow
);

    logic [CNT_W-1:0] i_q, i_d;
    logic [CNT_W-1:0] limit_q;
    logic             limit_en;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [SUM_W:0]   sum_ext;
    logic             ovf_q, ovf_d;
    logic             out_valid_q;

    always_comb begin
        i_d      = (MuxSel == MUX_INC) ? i_q + 1'b1 : '0;
        limit_en = En && (MuxSel == MUX_ZERO);
    end

    dp_register #(.W(CNT_W)) u_i_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (En),
        .d_i  (i_d),
        .q_o  (i_q)
    );

    dp_register #(.W(CNT_W)) u_limit_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (limit_en),
        .d_i  (limit),
        .q_o  (limit_q)
    );

    // One extra bit captures the carry-out that sets the sticky overflow flag.
    always_comb begin
        sum_ext = {1'b0, sum_q} + {{(SUM_W + 1 - CNT_W){1'b0}}, i_q};
        sum_d   = (MuxSel_2 == MUX_INC) ? sum_ext[SUM_W-1:0] : '0;
        ovf_d   = ovf_q;
        if (En_2) begin
            if (MuxSel_2 == MUX_ZERO) begin
                ovf_d = 1'b0;
            end else if (sum_ext[SUM_W]) begin
                ovf_d = 1'b1;
            end
        end
    end

    dp_register #(.W(SUM_W)) u_sum_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (En_2),
        .d_i  (sum_d),
        .q_o  (sum_q)
    );

    dp_register #(.W(SUM_W)) u_out_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (OutBuf),
        .d_i  (sum_q),
        .q_o  (out_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            ovf_q       <= ovf_d;
            out_valid_q <= OutBuf;
        end
    end

    assign lt        = (i_q < limit_q);
    assign overflow  = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_datapath.sv
// Bench: controller-style loops drive a 16-bit and an 8-bit accumulator instance; a
// scoreboard checks each presented result against the closed-form sum N(N+1)/2.
module tb_adder_datapath;

    logic        clk;
    logic        rst;
    logic        MuxSel, En, MuxSel_2, En_2, OutBuf;
    logic [7:0]  limit;
    logic        lt16, lt8;
    logic [15:0] data16;
    logic [7:0]  data8;
    logic        v16, v8, ovf16, ovf8;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] data;
        logic        ovf;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    exp_t cur16, cur8;
    logic prev_v16 = 1'b0;
    logic prev_v8  = 1'b0;

    adder_datapath #(.CNT_W(8), .SUM_W(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .MuxSel    (MuxSel),
        .En        (En),
        .MuxSel_2  (MuxSel_2),
        .En_2      (En_2),
        .OutBuf    (OutBuf),
        .limit     (limit),
        .lt        (lt16),
        .out_data  (data16),
        .out_valid (v16),
        .overflow  (ovf16)
    );

    adder_datapath #(.CNT_W(8), .SUM_W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .MuxSel    (MuxSel),
        .En        (En),
        .MuxSel_2  (MuxSel_2),
        .En_2      (En_2),
        .OutBuf    (OutBuf),
        .limit     (limit),
        .lt        (lt8),
        .out_data  (data8),
        .out_valid (v8),
        .overflow  (ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ctrl();
        En = 1'b0; MuxSel = 1'b0; En_2 = 1'b0; MuxSel_2 = 1'b0; OutBuf = 1'b0;
    endtask

    // Scoreboard monitors: pop on the rising edge of out_valid, then hold that value.
    always @(negedge clk) begin
        if (rst && v16) begin
            if (!prev_v16) begin
                if (q16.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_valid16: got data %0d with empty queue", data16);
                end else begin
                    cur16 = q16.pop_front();
                end
            end
            check("out_data16", 32'(data16), 32'(cur16.data));
            check("overflow16", 32'(ovf16), 32'(cur16.ovf));
        end
        prev_v16 = rst && v16;
    end

    always @(negedge clk) begin
        if (rst && v8) begin
            if (!prev_v8) begin
                if (q8.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_valid8: got data %0d with empty queue", data8);
                end else begin
                    cur8 = q8.pop_front();
                end
            end
            check("out_data8", 32'(data8), 32'(cur8.data));
            check("overflow8", 32'(ovf8), 32'(cur8.ovf));
        end
        prev_v8 = rst && v8;
    end

    // Plays the controller: init, then compare / increment / add per iteration, then halt.
    task automatic run_loop(input int n);
        int   i_m;
        int   iters;
        bit   done;
        longint tri_sum;
        exp_t e;
        idle_ctrl();
        limit = 8'(n);
        En = 1'b1; MuxSel = 1'b0; En_2 = 1'b1; MuxSel_2 = 1'b0;
        step();
        i_m   = 0;
        iters = 0;
        done  = 1'b0;
        while (!done) begin
            idle_ctrl();
            limit = 8'($urandom_range(0, 255));
            #1;
            check("lt16", 32'(lt16), 32'(i_m < n));
            check("lt8", 32'(lt8), 32'(i_m < n));
            if (i_m >= n) begin
                done = 1'b1;
            end else begin
                step();
                En = 1'b1; MuxSel = 1'b1;
                step();
                i_m++;
                idle_ctrl();
                En_2 = 1'b1; MuxSel_2 = 1'b1;
                step();
            end
            iters++;
            if (iters > 300) begin
                total++; bad++;
                $display("FAIL loop_timeout: got %0d iterations expected at most 300", iters);
                done = 1'b1;
            end
        end
        step();
        tri_sum = longint'(n) * longint'(n + 1) / 2;
        e.data = 16'(tri_sum % 65536);
        e.ovf  = (tri_sum >= 65536);
        q16.push_back(e);
        e.data = 16'(tri_sum % 256);
        e.ovf  = (tri_sum >= 256);
        q8.push_back(e);
        OutBuf = 1'b1;
        repeat (3) step();
        OutBuf = 1'b0;
        step();
        check("valid16_drop", 32'(v16), 32'd0);
        check("valid8_drop", 32'(v8), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        En = 1'b1; MuxSel = 1'b1; En_2 = 1'b1; MuxSel_2 = 1'b1; OutBuf = 1'b1;
        limit = 8'hff;
        step();
        step();
        check("rst_i", 32'(dut16.i_q), 32'd0);
        check("rst_sum", 32'(dut16.sum_q), 32'd0);
        check("rst_out_data", 32'(data16), 32'd0);
        check("rst_valid", 32'(v16), 32'd0);
        check("rst_overflow", 32'(ovf16), 32'd0);
        check("rst_lt", 32'(lt16), 32'd0);
        idle_ctrl();
        rst = 1'b1;
        step();

        run_loop(10);
        run_loop(0);
        run_loop(30);

        // Directed: build i=3, sum=6, then step counter and accumulator together.
        idle_ctrl();
        limit = 8'd10;
        En = 1'b1; MuxSel = 1'b0; En_2 = 1'b1; MuxSel_2 = 1'b0;
        step();
        limit = 8'd5;
        repeat (3) begin
            idle_ctrl();
            En = 1'b1; MuxSel = 1'b1;
            step();
            idle_ctrl();
            En_2 = 1'b1; MuxSel_2 = 1'b1;
            step();
        end
        check("dir_i3", 32'(dut16.i_q), 32'd3);
        check("dir_sum6", 32'(dut16.sum_q), 32'd6);
        En = 1'b1; MuxSel = 1'b1; En_2 = 1'b1; MuxSel_2 = 1'b1;
        step();
        check("dir_i4", 32'(dut16.i_q), 32'd4);
        check("dir_sum9", 32'(dut16.sum_q), 32'd9);
        idle_ctrl();
        En = 1'b1; MuxSel = 1'b1;
        repeat (2) step();
        idle_ctrl();
        check("lt_limit_latched", 32'(lt16), 32'd1);
        En = 1'b1; MuxSel = 1'b0;
        step();
        En = 1'b1; MuxSel = 1'b1;
        repeat (6) step();
        idle_ctrl();
        check("lt_new_limit", 32'(lt16), 32'd0);

        // Mid-loop reset with every control asserted.
        rst = 1'b0;
        En = 1'b1; MuxSel = 1'b1; En_2 = 1'b1; MuxSel_2 = 1'b1; OutBuf = 1'b1;
        step();
        check("midrst_i", 32'(dut16.i_q), 32'd0);
        check("midrst_sum", 32'(dut16.sum_q), 32'd0);
        check("midrst_out_data", 32'(data16), 32'd0);
        check("midrst_valid", 32'(v16), 32'd0);
        check("midrst_overflow8", 32'(ovf8), 32'd0);
        check("midrst_lt", 32'(lt16), 32'd0);
        idle_ctrl();
        rst = 1'b1;
        step();

        run_loop(255);
        repeat (5) run_loop(int'($urandom_range(0, 40)));

        repeat (3) step();
        check("q16_drained", 32'(q16.size()), 32'd0);
        check("q8_drained", 32'(q8.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_datapath.md
Name: adder_datapath

Overview:
- Datapath paired with the adder-loop ControllerUnit (sum of 1..N dedicated processor).
- Takes the controller's mux-select, enable and output-buffer strobes.
- Holds the loop counter, accumulator and latched limit; returns the `lt` compare flag to the controller.
- Drives a registered result with valid and a sticky overflow flag toward the display/output stage.

Parameters:
- CNT_W, 8, width of loop counter i and of limit.
- SUM_W, 16, width of accumulator sum and of out_data.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk).
- MuxSel  input  1  counter input select: 0 = load zero, 1 = load i+1.
- En  input  1  counter register load enable.
- MuxSel_2  input  1  accumulator input select: 0 = load zero, 1 = load sum+i.
- En_2  input  1  accumulator register load enable.
- OutBuf  input  1  output buffer enable from controller.
- limit  input  CNT_W  loop bound N; latched at counter init.
- lt  output  1  combinational flag, i_q < limit_q.
- out_data  output  SUM_W  registered result.
- out_valid  output  1  registered; high while a result is presented.
- overflow  output  1  sticky accumulator wrap flag.

Behaviour:
- Reset (rst=0 at clk edge): i_q, sum_q, limit_q, out_data, overflow = 0; out_valid = 0. Reset mid-loop aborts the loop; all state returns to these values the next edge. Reset dominates all control inputs.
- Counter:
  - En=1, MuxSel=0: i_q <= 0 and limit_q <= limit (init).
  - En=1, MuxSel=1: i_q <= i_q+1, mod 2^CNT_W. limit_q is held.
  - En=0: hold.
- Accumulator:
  - En_2=1, MuxSel_2=0: sum_q <= 0 and overflow <= 0.
  - En_2=1, MuxSel_2=1: sum_q <= sum_q + zero-extended i_q, truncated to SUM_W. If the carry-out is 1, overflow <= 1; it stays set until the next accumulator clear or reset.
  - En_2=0: hold.
- Counter and accumulator are independent. Both enabled in the same cycle: the accumulator uses the pre-edge i_q.
- lt:
  - Purely combinational from i_q and limit_q (unsigned compare); no input-to-output path from limit.
  - Valid in the controller's compare state, one cycle after any counter update.
- Output buffer:
  - OutBuf=1: out_data <= sum_q, out_valid <= 1.
  - OutBuf=0: out_data holds its last value, out_valid <= 0.
  - Latency is 1 clk from OutBuf to out_data/out_valid.
  - OutBuf held high (controller halt state): out_valid stays high and out_data tracks sum_q (stable).
- Unknown/illegal control combinations do not exist: each mux is 2:1 and fully decoded.
- limit = 0: lt = 0 immediately after init; result 0.
- Counter wrap: with limit = 2^CNT_W-1, i_q reaches the limit and lt falls, so no wrap occurs in legal operation.
- Expected cycle count with the controller: 4 + 3·N cycles to the halt state; out_valid rises 1 cycle later.

Decomposition:
- Package adder_dp_pkg holds:
  - CNT_W and SUM_W defaults.
  - Localparams MUX_ZERO=0 and MUX_INC=1.
- One sub-module, dp_register (parameter W):
  - Synchronous active-low reset and load enable.
  - Instantiated for i_q, limit_q, sum_q and out_data.
- Adder, comparator and muxes stay inline in adder_datapath.

Test Plan:
- Reset: drive rst=0 for 2 cycles with all controls at 1 -> i_q=0, sum_q=0, out_data=0, out_valid=0, overflow=0, lt=0.
- Full loop with ControllerUnit, limit=10 -> lt falls when i_q=10; out_valid=1 one cycle after OutBuf rises; out_data=55, overflow=0.
- limit=0 -> controller goes straight from compare to halt; out_data=0, out_valid=1.
- SUM_W=8, limit=30 -> true sum 465 wraps to out_data=465 mod 256=209; overflow=1 and stays 1 while halted.
- Directed control: En and En_2 both 1 with MuxSel=MuxSel_2=1, i_q=3, sum_q=6 -> next edge i_q=4, sum_q=9. Then rst=0 mid-loop -> all registers 0 next edge.
- Change limit from 10 to 5 after init -> lt unaffected (limit_q still 10) until the next En=1, MuxSel=0 init.
